// File: rtl/cache_nway_wb_pkg.sv
// Shared types and default geometry for the N-way
// write-back cache.
package cache_types;

    localparam int S_OFFSET_DEF = 5;
    localparam int S_INDEX_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } cache_state_t;

endpackage

// File: rtl/cache_nway_wb_if.sv
// CPU-side line bus and memory-side line bus of the cache.
// slave is the cache view, master is the environment view.
interface cache_nway_wb_if
    import cache_types::*;
#(
    parameter int s_offset = S_OFFSET_DEF
);
    localparam int s_mask = 2**s_offset;
    localparam int s_line = 8*s_mask;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [s_line-1:0] mem_wdata256;
    logic [s_mask-1:0] mem_byte_enable256;
    logic [s_line-1:0] mem_rdata256;
    logic              mem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address,
        input  mem_wdata256, mem_byte_enable256,
        output mem_rdata256, mem_resp,
        output pmem_read, pmem_write, pmem_address,
        output pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_address,
        output mem_wdata256, mem_byte_enable256,
        input  mem_rdata256, mem_resp,
        input  pmem_read, pmem_write, pmem_address,
        input  pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_nway_wb_plru.sv
// Tree pseudo-LRU state per set. Node n has children 2n+1
// (left) and 2n+2 (right); bit 0 points the victim left.
module plru_tree #(
    parameter int num_ways = 4,
    parameter int num_sets = 8,
    localparam int LW = $clog2(num_ways),
    localparam int SW = $clog2(num_sets)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] idx_i,
    input  logic          upd_i,
    input  logic [LW-1:0] way_i,
    output logic [LW-1:0] victim_o
);

    typedef logic [num_ways-2:0] vec_t;
    typedef logic [LW:0]         node_t;

    localparam vec_t  V1 = vec_t'(1);
    localparam node_t N1 = node_t'(1);

    vec_t bits_q [num_sets];
    vec_t bits_d;

    vec_t          vcur;
    vec_t          vsh;
    node_t         vnode;
    logic          vbit;
    logic [LW-1:0] vway;

    always_comb begin
        vcur  = bits_q[idx_i];
        vsh   = '0;
        vnode = '0;
        vbit  = 1'b0;
        vway  = '0;
        for (int d = 0; d < LW; d++) begin
            vsh     = vcur >> vnode;
            vbit    = vsh[0];
            vway    = vway << 1;
            vway[0] = vbit;
            vnode   = (vnode << 1) + N1 + node_t'(vbit);
        end
        victim_o = vway;
    end

    node_t         unode;
    logic          udir;
    logic [LW-1:0] ush;

    // Each node on the path is pointed away from the accessed way.
    always_comb begin
        bits_d = bits_q[idx_i];
        unode  = '0;
        udir   = 1'b0;
        ush    = '0;
        for (int d = 0; d < LW; d++) begin
            ush    = way_i >> (LW - 1 - d);
            udir   = ush[0];
            bits_d = (bits_d & ~(V1 << unode))
                   | (vec_t'(!udir) << unode);
            unode  = (unode << 1) + N1 + node_t'(udir);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                bits_q[s] <= '0;
            end
        end else if (upd_i) begin
            bits_q[idx_i] <= bits_d;
        end
    end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back cache: flop arrays,
// tree-PLRU replacement and the miss-handling FSM.
module cache_nway_wb
    import cache_types::*;
#(
    parameter int s_offset = S_OFFSET_DEF,
    parameter int s_index  = S_INDEX_DEF,
    parameter int num_ways = 4
) (
    input logic            clk,
    input logic            rst,
    cache_nway_wb_if.slave bus
);

    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int s_mask   = 2**s_offset;
    localparam int s_line   = 8*s_mask;
    localparam int num_sets = 2**s_index;
    localparam int LW       = $clog2(num_ways);

    typedef logic [LW-1:0] way_t;

    cache_state_t state_q, state_d;
    way_t         victim_q, victim_d;

    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [s_line-1:0]   data_q  [num_sets][num_ways];

    logic [s_tag-1:0]   tag;
    logic [s_index-1:0] idx;
    logic               wr;
    logic               req;
    logic               unused_offset;

    assign tag = bus.mem_address[31 -: s_tag];
    assign idx = bus.mem_address[s_offset +: s_index];
    assign wr  = bus.mem_write;
    assign req = bus.mem_read | bus.mem_write;
    assign unused_offset = ^bus.mem_address[s_offset-1:0];

    logic hit;
    way_t hit_way;
    logic any_inv;
    way_t inv_way;
    way_t plru_victim;
    way_t pick_way;

    // Descending scan so the lowest matching/invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[idx][w]) begin
                any_inv = 1'b1;
                inv_way = way_t'(w);
            end
        end
        pick_way = any_inv ? inv_way : plru_victim;
    end

    logic [s_line-1:0] hit_data;
    logic [s_line-1:0] merged;

    always_comb begin
        hit_data = data_q[idx][hit_way];
        merged   = hit_data;
        for (int b = 0; b < s_mask; b++) begin
            if (bus.mem_byte_enable256[b]) begin
                merged[8*b +: 8] = bus.mem_wdata256[8*b +: 8];
            end
        end
    end

    logic              arr_we;
    way_t              arr_way;
    logic [s_line-1:0] arr_data;
    logic              arr_dirty;
    logic              plru_upd;

    logic              resp;
    logic [s_line-1:0] rdata;
    logic              prd;
    logic              pwr;
    logic [31:0]       paddr;
    logic [s_line-1:0] pwdata;

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        arr_we    = 1'b0;
        arr_way   = hit_way;
        arr_data  = merged;
        arr_dirty = 1'b0;
        plru_upd  = 1'b0;
        resp      = 1'b0;
        rdata     = '0;
        prd       = 1'b0;
        pwr       = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = CHECK;
            end
            CHECK: begin
                if (hit) begin
                    resp     = 1'b1;
                    plru_upd = 1'b1;
                    state_d  = IDLE;
                    if (wr) begin
                        arr_we    = 1'b1;
                        arr_dirty = 1'b1;
                    end else begin
                        rdata = hit_data;
                    end
                end else begin
                    victim_d = pick_way;
                    if (valid_q[idx][pick_way] &&
                        dirty_q[idx][pick_way])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end
            WRITEBACK: begin
                pwr    = 1'b1;
                paddr  = {tag_q[idx][victim_q], idx,
                          {s_offset{1'b0}}};
                pwdata = data_q[idx][victim_q];
                if (bus.pmem_resp) state_d = FILL;
            end
            FILL: begin
                prd   = 1'b1;
                paddr = {tag, idx, {s_offset{1'b0}}};
                if (bus.pmem_resp) begin
                    arr_we   = 1'b1;
                    arr_way  = victim_q;
                    arr_data = bus.pmem_rdata;
                    state_d  = CHECK;
                end
            end
        endcase
    end

    assign bus.mem_resp     = resp;
    assign bus.mem_rdata256 = rdata;
    assign bus.pmem_read    = prd;
    assign bus.pmem_write   = pwr;
    assign bus.pmem_address = paddr;
    assign bus.pmem_wdata   = pwdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (arr_we) begin
                valid_q[idx][arr_way] <= 1'b1;
                dirty_q[idx][arr_way] <= arr_dirty;
            end
        end
    end

    // Tag and data carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[idx][arr_way]  <= tag;
            data_q[idx][arr_way] <= arr_data;
        end
    end

    plru_tree #(
        .num_ways (num_ways),
        .num_sets (num_sets)
    ) u_plru (
        .clk      (clk),
        .rst      (rst),
        .idx_i    (idx),
        .upd_i    (plru_upd),
        .way_i    (hit_way),
        .victim_o (plru_victim)
    );

endmodule

// File: doc/cache_nway_wb.md
# cache_nway_wb

Parametrised N-way set-associative write-back cache: array storage, tree pseudo-LRU replacement and the miss-handling FSM in one block. Sits between the CPU-side line adaptor (256-bit line requests with byte enables) and physical memory or the next cache level. It generalises the fixed 2-way cache to any power-of-two way count. It also adds invalid-way-first allocation and a tree-PLRU policy.

## Interface
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes
- s_index, 3, index bits; num_sets = 2**s_index
- num_ways, 4, associativity; power of two, 2..16
- s_tag, 32-s_offset-s_index, tag width (derived)
- s_mask, 2**s_offset, byte-enable width (derived)
- s_line, 8*s_mask, line width in bits (derived)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU line read request, held until mem_resp
- mem_write  in  1  CPU line write request, held until mem_resp
- mem_address  in  32  request byte address; offset bits ignored
- mem_wdata256  in  s_line  write line
- mem_byte_enable256  in  s_mask  per-byte write enable
- mem_rdata256  out  s_line  read line, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line-aligned memory address, low s_offset bits zero
- pmem_wdata  out  s_line  writeback line
- pmem_rdata  in  s_line  fill line, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- Address split: offset [s_offset-1:0], index next s_index bits, tag the remaining upper bits.
- Per set and way, the cache holds valid, dirty, tag and data. Each set also holds num_ways-1 PLRU bits.
- FSM states are IDLE, CHECK, WRITEBACK and FILL.
  - IDLE, when mem_read or mem_write is seen: go to CHECK.
- CHECK, hit when valid and tag match in exactly one way:
  - Read hit: mem_rdata256 = hit way data; mem_resp=1; go to IDLE.
  - Write hit: merge mem_wdata256 into hit-way bytes where the enable is 1; set dirty; mem_resp=1; go to IDLE.
  - Either hit updates the PLRU along the hit way's path.
- CHECK, miss: select the victim.
  - Victim = lowest-index invalid way, else the PLRU victim.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to FILL.
  - The victim index is registered on leaving CHECK.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim data. On pmem_resp, go to FILL.
- FILL: pmem_read=1, pmem_address={mem_address tag, index, 0}. On pmem_resp:
  - victim way gets data=pmem_rdata, tag, valid=1, dirty=0;
  - go to CHECK, which then hits; write misses merge in CHECK (write-allocate).
- PLRU tree:
  - Node bit 0 means "victim lies in the left subtree".
  - On access, each node on the accessed way's path is set to point away from that way.
  - The victim is found by following the bits from the root.
- Both mem_read and mem_write asserted: treated as a write.
- pmem_resp outside WRITEBACK/FILL: ignored.
- Multiple-way tag match cannot arise; no priority logic is required beyond lowest index.

## Timing
- Reset, asynchronous:
  - state=IDLE; all valid, dirty and PLRU bits = 0;
  - mem_resp, pmem_read, pmem_write = 0, mem_rdata256, pmem_address, pmem_wdata = 0; the drops take effect immediately, not at the next edge;
  - tag and data arrays are not reset.
- Reset mid-miss: the transaction is abandoned; memory may see a truncated request.
- Hit latency: request present on edge 0 → mem_resp high for exactly the cycle after edge 1.
- Clean miss: mem_resp comes 2 cycles after the pmem_resp of FILL. A dirty miss adds the WRITEBACK phase.
- pmem_read and pmem_write are never high together. pmem_address is stable while either is high.
- Array writes occur on the edge that leaves CHECK (hit) or FILL.
- Reads are combinational from flop arrays.
- CPU inputs must remain stable until mem_resp. The next request may start the cycle after mem_resp.

## Structure
- Shared package cache_types:
  - cache_state_t enum {IDLE, CHECK, WRITEBACK, FILL};
  - default s_offset and s_index constants.
- Sub-module plru_tree #(num_ways, num_sets):
  - holds PLRU bits with async reset;
  - inputs: index, update strobe, accessed way;
  - output: victim way, $clog2(num_ways) bits.
- The top holds the FSM, arrays, hit/victim logic and byte-merge.

## Test plan
- Reset, then read 0x0000_1000 (num_ways=4) → FILL with pmem_address 0x0000_1000; after pmem_resp, mem_resp and data = pmem_rdata; the re-read hits in 2 cycles with no pmem activity.
- Write 0xAA to byte 3 with enable 0x0000_0008 at a cached line → a later read returns the line with only byte 3 changed. The line is dirty and pmem is untouched.
- Fill 5 distinct tags into set 0 with 4 ways, accessing ways in order 0,1,2,3 → the fifth evicts way 0. Reaching way 3 by the 4th fill confirms invalid-first allocation.
- Evict a dirty line → pmem_write with the old tag address and the dirty data, then pmem_read of the new address; pmem_read and pmem_write never overlap.
- Assert rst during FILL with pmem_read=1 → pmem_read drops before the next edge. After reset, a read of the same address misses again (valid cleared).
- Both mem_read and mem_write asserted → behaves as a write and mem_resp pulses once.
